// File: rtl/uart_rx_stdin_pkg.sv
// uart_rx_stdin_pkg
//   Shared definitions for the stdin UART receiver: receiver FSM state
//   encoding and the number of data bits per frame.
//   Optional feature macro used by the importing files: UART_RX_PARITY_EN.
package uart_rx_stdin_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_stdin_sync_fifo.sv
// uart_rx_stdin_sync_fifo
//   Small show-ahead FIFO: rdata always presents the head entry, so a pop
//   in consecutive cycles streams entries with no bubble.
//   Ports:
//     clk, rstn      clock, async active-low reset (pointers and storage cleared)
//     push, wdata    write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//     pop            remove head; ignored when empty
//     rdata          head entry
//     full, empty    occupancy flags
module uart_rx_stdin_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // One extra pointer bit separates full from empty when the index bits match.
    logic [DEPTH_LOG2:0]             wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]     mem;
    logic                            do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_stdin.sv
// uart_rx_stdin
//   8N1 UART receiver feeding the CPU stdin path. The async line is
//   double-synchronised, the start bit is re-checked at mid-bit, data is
//   sampled mid-bit LSB first, and the stop bit is checked before the byte
//   is pushed into a show-ahead FIFO.
//   Macro UART_RX_PARITY_EN: expect an even-parity bit after data bit 7 and
//   add the parity_err output.
//   Ports:
//     clk, rstn   clock, async active-low reset
//     rx          serial line (async, idle high)
//     rd_data     FIFO head byte, valid while rd_valid
//     rd_valid    FIFO non-empty
//     rd_en       pop head this cycle (ignored when rd_valid=0)
//     frame_err   1-cycle pulse: stop bit was 0, byte discarded
//     overrun     1-cycle pulse: good byte dropped because FIFO full
//     parity_err  1-cycle pulse: parity mismatch, byte discarded (option)
//     busy        a frame is being received
module uart_rx_stdin
    import uart_rx_stdin_pkg::*;
#(
    parameter int BAUD       = 104,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_en,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CW = $clog2(BAUD);

    logic                  rx_meta, rx_s, rx_d;
    rx_state_t             state, state_n;
    logic [CW-1:0]         baud_cnt;
    logic [2:0]            bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  expire;
    logic                  cnt_half, cnt_full, shift_en, push_req, ferr_set;
    logic                  fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                  par_chk, perr_set, par_bad;
`endif

    // Sync flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign expire = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_half = 1'b0;
        cnt_full = 1'b0;
        shift_en = 1'b0;
        push_req = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk  = 1'b0;
        perr_set = 1'b0;
`endif
        case (state)
            IDLE: if (rx_d && !rx_s) begin
                cnt_half = 1'b1;
                state_n  = START;
            end
            START: if (expire) begin
                // A high line at mid-start is a glitch: drop it silently.
                if (!rx_s) begin
                    cnt_full = 1'b1;
                    state_n  = DATA;
                end else begin
                    state_n  = IDLE;
                end
            end
            DATA: if (expire) begin
                shift_en = 1'b1;
                cnt_full = 1'b1;
                if (bit_idx == 3'(FRAME_BITS - 1))
`ifdef UART_RX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (expire) begin
                par_chk  = 1'b1;
                cnt_full = 1'b1;
                state_n  = STOP;
            end
`endif
            STOP: if (expire) begin
                // Back to IDLE at mid-stop so a following start edge is caught.
                state_n = IDLE;
                if (!rx_s)
                    ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                else if (par_bad)
                    perr_set = 1'b1;
`endif
                else
                    push_req = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            if (cnt_half)
                baud_cnt <= CW'(BAUD / 2 - 1);
            else if (cnt_full)
                baud_cnt <= CW'(BAUD - 1);
            else if (state != IDLE && !expire)
                baud_cnt <= baud_cnt - 1'b1;

            if (state == START)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;

            if (shift_en)
                shreg <= {rx_s, shreg[FRAME_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data plus parity bit must hold an even number of ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                par_bad <= 1'b0;
        else if (state == START)  par_bad <= 1'b0;
        else if (par_chk)         par_bad <= ^{shreg, rx_s};
    end
`endif

    // Full with a same-cycle pop still accepts, so overrun needs !rd_en too.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= ferr_set;
            overrun    <= push_req && fifo_full && !rd_en;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_set;
`endif
        end
    end

    uart_rx_stdin_sync_fifo #(
        .WIDTH      (FRAME_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .wdata (shreg),
        .pop   (rd_en),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign busy     = (state != IDLE);

endmodule
